// File: rtl/booth_mul_ctrl_if.sv
// rtl/booth_mul_ctrl_if.sv - operand/result handshake bundle for booth_mul_ctrl
//
// Purpose: groups the operand-side and result-side valid/ready handshakes of
// the Booth multiplier controller.
// Signals:
//   in_valid / in_ready   operand pair handshake (master -> slave)
//   mcand, mplier         signed W-bit operands
//   out_valid / out_ready product handshake (slave -> master)
//   product               signed 2W-bit product
//   busy                  controller is iterating
//   abort                 only with MUL_ABORT_EN: cancel the current operation
interface booth_mul_ctrl_if #(
  parameter int W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
`ifdef MUL_ABORT_EN
  logic           abort;
`endif

  modport master (
`ifdef MUL_ABORT_EN
    output abort,
`endif
    output in_valid, mcand, mplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
`ifdef MUL_ABORT_EN
    input  abort,
`endif
    input  in_valid, mcand, mplier, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_mul_ctrl.sv
// rtl/booth_mul_ctrl.sv - multi-cycle radix-2 Booth signed multiplier controller
//
// Purpose: accepts a signed operand pair, runs W radix-2 Booth iterations
// (one per clock) through a single W+1 bit ripple adder/subtractor, and
// presents the registered 2W-bit product until the consumer takes it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    booth_mul_ctrl_if.slave: in_valid/in_ready/mcand/mplier,
//          out_valid/out_ready/product, busy (and abort when enabled)
// Optional feature macro: MUL_ABORT_EN adds bus.abort, which cancels an
// operation in RUN or DONE and returns to IDLE with the product unchanged.

// Ripple-carry adder/subtractor; sub both inverts b and injects the carry-in.
module booth_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] s
);
  logic [N-1:0] b_eff;
  logic         carry;

  always_comb begin
    b_eff = b ^ {N{sub}};
    carry = sub;
    s     = '0;
    for (int i = 0; i < N; i++) begin
      s[i]  = a[i] ^ b_eff[i] ^ carry;
      carry = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
    end
  end
endmodule

module booth_mul_ctrl #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_mul_ctrl_if.slave  bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_next;

  logic [W:0]     acc_a;
  logic [W:0]     m_reg;
  logic [W-1:0]   q_reg;
  logic           q_1;
  logic [CW-1:0]  count;
  logic [2*W-1:0] product_reg;

  logic           abort_req;
  logic           accept;
  logic           last_iter;
  logic           in_ready_c;
  logic           busy_c;
  logic           out_valid_c;

  logic           add_en;
  logic           sub;
  logic [W:0]     addsub_out;
  logic [W:0]     sum;
  logic [W:0]     a_nxt;
  logic [W-1:0]   q_nxt;
  logic           q1_nxt;

`ifdef MUL_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Abort in IDLE blocks acceptance on that edge.
  assign accept    = (state == IDLE) && bus.in_valid && !abort_req;
  assign last_iter = (count == CW'(W - 1));

  // Booth recoding: 01 adds M, 10 subtracts M, 00/11 pass A through.
  assign add_en = q_reg[0] ^ q_1;
  assign sub    = q_reg[0] & ~q_1;

  booth_addsub #(.N(W + 1)) u_addsub (
    .a   (acc_a),
    .b   (m_reg),
    .sub (sub),
    .s   (addsub_out)
  );

  assign sum = add_en ? addsub_out : acc_a;

  // Arithmetic shift right of {sum, Q, q_1}; sum MSB replicated.
  assign a_nxt  = {sum[W], sum[W:1]};
  assign q_nxt  = {sum[0], q_reg[W-1:1]};
  assign q1_nxt = q_reg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    busy_c      = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (abort_req) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (abort_req || bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a       <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      q_1         <= 1'b0;
      count       <= '0;
      product_reg <= '0;
    end else begin
      if (accept) begin
        m_reg <= {bus.mcand[W-1], bus.mcand};
        acc_a <= '0;
        q_reg <= bus.mplier;
        q_1   <= 1'b0;
        count <= '0;
      end else if (state == RUN && !abort_req) begin
        acc_a <= a_nxt;
        q_reg <= q_nxt;
        q_1   <= q1_nxt;
        count <= count + 1'b1;
        if (last_iter) begin
          // Top bit of the widened accumulator is pure sign and is dropped.
          product_reg <= {a_nxt[W-1:0], q_nxt};
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.product   = product_reg;
endmodule

// File: tb/tb_booth_mul_ctrl.sv
// tb/tb_booth_mul_ctrl.sv - directed self-checking bench for booth_mul_ctrl
module tb_booth_mul_ctrl;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  booth_mul_ctrl_if #(.W(W)) bus ();

  booth_mul_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand pair, scrambles the operands after acceptance, and
  // returns the number of edges from accept to out_valid plus the product.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [2*W-1:0] p);
    @(negedge clk);
    bus.mcand    = a;
    bus.mplier   = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.mcand    = 32'hDEAD_BEEF;
    bus.mplier   = 32'h1234_5678;
    lat = 0;
    p   = '0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    p = bus.product;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mcand     = '0;
    bus.mplier    = '0;
`ifdef MUL_ABORT_EN
    bus.abort     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.product !== 64'h0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 0",
                 i, bus.in_ready, bus.out_valid, bus.busy, bus.product);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [2*W-1:0] p;
    bus.out_ready = 1'b1;
    fork
      run_op(32'd7, 32'hFFFF_FFFD, lat, p);
      begin
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL run_flags: busy=%b in_ready=%b, want 1 0", bus.busy, bus.in_ready);
        end
      end
    join
    tests++;
    if (lat !== 32) begin
      fails++;
      $display("FAIL latency_7x-3: got %0d edges, want 32", lat);
    end
    tests++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      fails++;
      $display("FAIL product_7x-3: got %h, want ffffffffffffffeb", p);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL return_idle: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_corners();
    int lat;
    logic [2*W-1:0] p;
    bus.out_ready = 1'b1;
    run_op(32'h8000_0000, 32'h8000_0000, lat, p);
    tests++;
    if (p !== 64'h4000_0000_0000_0000 || lat !== 32) begin
      fails++;
      $display("FAIL minxmin: got %h lat %0d, want 4000000000000000 lat 32", p, lat);
    end
    run_op(32'h8000_0000, 32'd1, lat, p);
    tests++;
    if (p !== 64'hFFFF_FFFF_8000_0000) begin
      fails++;
      $display("FAIL minx1: got %h, want ffffffff80000000", p);
    end
    run_op(32'd0, 32'd0, lat, p);
    tests++;
    if (p !== 64'h0 || lat !== 32) begin
      fails++;
      $display("FAIL zerox0: got %h lat %0d, want 0 lat 32", p, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [2*W-1:0] p;
    @(negedge clk);
    bus.out_ready = 1'b0;
    run_op(32'd12345, 32'd678, lat, p);
    tests++;
    if (p !== 64'h0000_0000_007F_B6F6) begin
      fails++;
      $display("FAIL bp_product: got %h, want 00000000007fb6f6", p);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (bus.product !== 64'h0000_0000_007F_B6F6 || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: product=%h out_valid=%b in_ready=%b, want 7fb6f6 1 0",
                 i, bus.product, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [2*W-1:0] p;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.mcand    = 32'h7FFF_FFFF;
    bus.mplier   = 32'd2;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.product !== 64'h0) begin
      fails++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd5, 32'd5, lat, p);
    tests++;
    if (p !== 64'd25 || lat !== 32) begin
      fails++;
      $display("FAIL after_reset_5x5: got %h lat %0d, want 19 lat 32", p, lat);
    end
  endtask

`ifdef MUL_ABORT_EN
  task automatic test_abort();
    int lat;
    int seen;
    logic [2*W-1:0] p;
    logic [2*W-1:0] before;
    bus.out_ready = 1'b1;
    before = bus.product;
    @(negedge clk);
    bus.mcand    = 32'd9;
    bus.mplier   = 32'd9;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== before) begin
      fails++;
      $display("FAIL abort_run: in_ready=%b out_valid=%b product=%h, want 1 0 %h",
               bus.in_ready, bus.out_valid, bus.product, before);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL abort_no_valid: out_valid seen %0d cycles, want 0", seen);
    end
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle_priority: busy=%b in_ready=%b, want 0 1", bus.busy, bus.in_ready);
    end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p);
    tests++;
    if (p !== 64'd1 || lat !== 32) begin
      fails++;
      $display("FAIL abort_next_m1xm1: got %h lat %0d, want 1 lat 32", p, lat);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
`ifdef MUL_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
